// File: rtl/thumb_prefetch_if.sv
// thumb_prefetch_if
//   Bundles the fetch-memory, redirect and core-side halfword signals of
//   thumb_prefetch_buf.
//   master : prefetch buffer view (drives mem_req/mem_addr and the halfword stream)
//   slave  : environment view (memory + core + redirect source)
//   Signals:
//     mem_req/mem_addr/mem_ack/mem_rdata   word fetch request/response
//     br_valid/br_target                   fetch redirect
//     inst_hw/hw_addr/hw_valid/hw_ready    halfword stream towards the core
//     hw_wide/hw_next                      only when THUMB_WIDE_PAIR_EN is defined
interface thumb_prefetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        br_valid;
    logic [31:0] br_target;
    logic [15:0] inst_hw;
    logic [31:0] hw_addr;
    logic        hw_valid;
    logic        hw_ready;
`ifdef THUMB_WIDE_PAIR_EN
    logic        hw_wide;
    logic [15:0] hw_next;

    modport master (
        output mem_req, mem_addr, inst_hw, hw_addr, hw_valid, hw_wide, hw_next,
        input  mem_ack, mem_rdata, br_valid, br_target, hw_ready
    );
    modport slave (
        input  mem_req, mem_addr, inst_hw, hw_addr, hw_valid, hw_wide, hw_next,
        output mem_ack, mem_rdata, br_valid, br_target, hw_ready
    );
`else
    modport master (
        output mem_req, mem_addr, inst_hw, hw_addr, hw_valid,
        input  mem_ack, mem_rdata, br_valid, br_target, hw_ready
    );
    modport slave (
        input  mem_req, mem_addr, inst_hw, hw_addr, hw_valid,
        output mem_ack, mem_rdata, br_valid, br_target, hw_ready
    );
`endif
endinterface

// File: rtl/thumb_prefetch_buf.sv
// thumb_prefetch_buf
//   Instruction prefetch buffer for arm_core. Fetches aligned 32-bit words
//   (one request outstanding at a time), splits them into Thumb halfwords in
//   a DEPTH-entry FIFO and hands the head halfword to the core with a
//   valid/ready handshake. A redirect flushes the FIFO; a request already in
//   flight is completed and its data dropped (DRAIN) before the new target
//   is fetched.
//   Ports:
//     clk   clock, rising edge
//     rst   synchronous active-high reset
//     bus   thumb_prefetch_if.master (memory, redirect and halfword stream)
//   Parameters:
//     DEPTH       halfword FIFO entries (power of 2, >= 4)
//     RESET_ADDR  byte address of the first fetch after reset
//   Build option:
//     THUMB_WIDE_PAIR_EN  when defined, adds hw_wide/hw_next; a 32-bit Thumb-2
//                         head is only offered once both halves are buffered
//                         and is consumed as a pair.
//
//   state | meaning
//   IDLE  | no request outstanding; waits for >= 2 free slots
//   REQ   | fetch of mem_addr outstanding; data is pushed on mem_ack
//   DRAIN | stale fetch outstanding after a redirect; data dropped on mem_ack
module thumb_prefetch_buf #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    thumb_prefetch_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Highest count that still leaves room for a full word (2 halfwords).
    localparam logic [CW-1:0] ROOM_MAX = CW'(DEPTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem_addr_q, hw_addr_q, br_tgt_q;
    logic          skip_q;
    logic [15:0]   last_hw_q;

    logic [15:0]   head, inst_hw_w;
    logic          hw_valid;
    logic          push, pop;
    logic [CW-1:0] push_cnt, pop_cnt;
    logic [PW-1:0] pop_step;
    logic [31:0]   addr_step;

    assign head      = fifo_q[rd_ptr_q];
    // When empty the core keeps seeing the last halfword it consumed.
    assign inst_hw_w = (count_q != '0) ? head : last_hw_q;

`ifdef THUMB_WIDE_PAIR_EN
    logic head_wide;
    // 11101, 11110, 11111 in [15:11] start a 32-bit Thumb-2 instruction.
    assign head_wide   = (inst_hw_w[15:13] == 3'b111) && (inst_hw_w[12:11] != 2'b00);
    assign bus.hw_wide = head_wide;
    assign bus.hw_next = fifo_q[rd_ptr_q + PW'(1)];
`endif

    always_comb begin
        hw_valid  = (count_q != '0);
        pop_step  = PW'(1);
        addr_step = 32'd2;
`ifdef THUMB_WIDE_PAIR_EN
        if (head_wide) begin
            hw_valid  = (count_q >= CW'(2));
            pop_step  = PW'(2);
            addr_step = 32'd4;
        end
`endif
        // A redirect overrides any push or pop in the same cycle.
        push     = (state_q == REQ) && bus.mem_ack && !bus.br_valid;
        pop      = hw_valid && bus.hw_ready && !bus.br_valid;
        push_cnt = '0;
        if (push) begin
            push_cnt = skip_q ? CW'(1) : CW'(2);
        end
        pop_cnt = '0;
        if (pop) begin
            pop_cnt = CW'(pop_step);
        end
        count_d = count_q + push_cnt - pop_cnt;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.br_valid || (count_q <= ROOM_MAX)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.br_valid) begin
                    // An ack in the redirect cycle closes the old request, so the
                    // new one can go out immediately; otherwise wait it out.
                    state_d = bus.mem_ack ? REQ : DRAIN;
                end else if (bus.mem_ack) begin
                    state_d = (count_d <= ROOM_MAX) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (bus.mem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            mem_addr_q <= RESET_ADDR & ~32'd3;
            hw_addr_q  <= RESET_ADDR;
            br_tgt_q   <= RESET_ADDR;
            skip_q     <= RESET_ADDR[1];
            last_hw_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + pop_step;
                hw_addr_q <= hw_addr_q + addr_step;
                last_hw_q <= head;
            end
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PW'(push_cnt);
                mem_addr_q <= mem_addr_q + 32'd4;
                skip_q     <= 1'b0;
            end
            if ((state_q == DRAIN) && bus.mem_ack) begin
                mem_addr_q <= br_tgt_q & ~32'd3;
            end
            if (bus.br_valid) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                count_q   <= '0;
                hw_addr_q <= bus.br_target & ~32'd1;
                skip_q    <= bus.br_target[1];
                br_tgt_q  <= bus.br_target;
                // mem_addr must stay stable while a request is still open.
                if ((state_q == IDLE) || bus.mem_ack) begin
                    mem_addr_q <= bus.br_target & ~32'd3;
                end
            end
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            if (skip_q) begin
                fifo_q[wr_ptr_q] <= bus.mem_rdata[31:16];
            end else begin
                fifo_q[wr_ptr_q]          <= bus.mem_rdata[15:0];
                fifo_q[wr_ptr_q + PW'(1)] <= bus.mem_rdata[31:16];
            end
        end
    end

    assign bus.mem_req  = (state_q != IDLE);
    assign bus.mem_addr = mem_addr_q;
    assign bus.inst_hw  = inst_hw_w;
    assign bus.hw_addr  = hw_addr_q;
    assign bus.hw_valid = hw_valid;

endmodule
